// File: rtl/median_pkg.sv
// Shared constants and types for the 3-input median selector.
package median_pkg;
  localparam int WIDTH_DEFAULT = 8;
  localparam int LATENCY       = 1;
  typedef logic [WIDTH_DEFAULT-1:0] sample_t;
endpackage

// File: rtl/median_cx.sv
// Combinational compare-exchange: lo = smaller of x/y, hi = larger; signedness by parameter.
module median_cx
  import median_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic swap;

  generate
    if (SIGNED) begin : g_s
      assign swap = $signed(x) > $signed(y);
    end else begin : g_u
      assign swap = x > y;
    end
  endgenerate

  assign lo = swap ? y : x;
  assign hi = swap ? x : y;
endmodule

// File: rtl/median.sv
// Streaming 3-tap median, one registered stage. Define MEDIAN_MINMAX_EN to
// also export the registered minimum (min_o) and maximum (max_o).
module median
  import median_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  output logic             out_valid,
`ifdef MEDIAN_MINMAX_EN
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o
`else
  output logic [WIDTH-1:0] out
`endif
);
  logic [WIDTH-1:0] lo1, hi1, lo2, hi2, mn, med;
  logic [LATENCY-1:0] vld_pipe;

  // lo1 = min(a0,a1); lo2 = min(max(a0,a1),a2); their max is the median,
  // their min the overall minimum, hi2 the overall maximum.
  median_cx #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cx0 (.x(a0),  .y(a1), .lo(lo1), .hi(hi1));
  median_cx #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cx1 (.x(hi1), .y(a2), .lo(lo2), .hi(hi2));
  median_cx #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cx2 (.x(lo1), .y(lo2), .lo(mn),  .hi(med));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= (vld_pipe << 1) | LATENCY'(in_valid);
  end
  assign out_valid = vld_pipe[LATENCY-1];

  // Data only loads on a valid beat, so idle-cycle operands never reach out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           out <= '0;
    else if (in_valid) out <= med;
  end

`ifdef MEDIAN_MINMAX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_o <= '0;
      max_o <= '0;
    end else if (in_valid) begin
      min_o <= mn;
      max_o <= hi2;
    end
  end
`else
  // min/max fall out of the network for free but have no consumer here.
  logic unused_minmax;
  assign unused_minmax = ^{mn, hi2};
`endif
endmodule

// File: tb/tb_median.sv
// Directed scoreboard bench for median: unsigned and signed instances side by side.
module tb_median;
  import median_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    in_valid;
  sample_t a0, a1, a2;
  logic    ov_u, ov_s;
  sample_t out_u, out_s;
`ifdef MEDIAN_MINMAX_EN
  sample_t mn_u, mx_u, mn_s, mx_s;
`endif

  always #5 clk = ~clk;

  median #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a0(a0), .a1(a1), .a2(a2),
`ifdef MEDIAN_MINMAX_EN
    .min_o(mn_u), .max_o(mx_u),
`endif
    .out_valid(ov_u), .out(out_u));

  median #(.WIDTH(8), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a0(a0), .a1(a1), .a2(a2),
`ifdef MEDIAN_MINMAX_EN
    .min_o(mn_s), .max_o(mx_s),
`endif
    .out_valid(ov_s), .out(out_s));

  typedef struct {
    sample_t med_u, med_s, mn_u, mx_u, mn_s, mx_s;
  } exp_t;

  exp_t sbq[$];
  exp_t held;
  int   ncmp  = 0;
  int   nfail = 0;

  // which: 0 = min, 1 = median, 2 = max
  function automatic sample_t model(sample_t x, sample_t y, sample_t z, bit sgn, int which);
    int ix, iy, iz, lo, hi;
    ix = sgn ? int'($signed(x)) : int'(x);
    iy = sgn ? int'($signed(y)) : int'(y);
    iz = sgn ? int'($signed(z)) : int'(z);
    lo = (ix < iy) ? ix : iy;  lo = (lo < iz) ? lo : iz;
    hi = (ix > iy) ? ix : iy;  hi = (hi > iz) ? hi : iz;
    if (which == 0) return sample_t'(lo);
    if (which == 2) return sample_t'(hi);
    return sample_t'(ix + iy + iz - lo - hi);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic zero_held();
    held = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  endtask

  task automatic check_outs(input bit v);
    chk("ov_u", {31'd0, ov_u}, {31'd0, v});
    chk("ov_s", {31'd0, ov_s}, {31'd0, v});
    chk("out_u", {24'd0, out_u}, {24'd0, held.med_u});
    chk("out_s", {24'd0, out_s}, {24'd0, held.med_s});
`ifdef MEDIAN_MINMAX_EN
    chk("min_u", {24'd0, mn_u}, {24'd0, held.mn_u});
    chk("max_u", {24'd0, mx_u}, {24'd0, held.mx_u});
    chk("min_s", {24'd0, mn_s}, {24'd0, held.mn_s});
    chk("max_s", {24'd0, mx_s}, {24'd0, held.mx_s});
`endif
  endtask

  // Drive one beat, let one edge pass, then compare against the scoreboard.
  task automatic beat(input bit v, input sample_t x0, input sample_t x1, input sample_t x2);
    exp_t e;
    in_valid = v; a0 = x0; a1 = x1; a2 = x2;
    if (v) begin
      e.med_u = model(x0, x1, x2, 1'b0, 1); e.med_s = model(x0, x1, x2, 1'b1, 1);
      e.mn_u  = model(x0, x1, x2, 1'b0, 0); e.mx_u  = model(x0, x1, x2, 1'b0, 2);
      e.mn_s  = model(x0, x1, x2, 1'b1, 0); e.mx_s  = model(x0, x1, x2, 1'b1, 2);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    if (v && sbq.size() > 0) held = sbq.pop_front();
    check_outs(v);
  endtask

  initial begin
    sample_t p [6][3];
    p = '{'{8'd3, 8'd200, 8'd77}, '{8'd3, 8'd77, 8'd200}, '{8'd200, 8'd3, 8'd77},
          '{8'd200, 8'd77, 8'd3}, '{8'd77, 8'd3, 8'd200}, '{8'd77, 8'd200, 8'd3}};

    // Reset with live inputs: nothing may leak through.
    rst = 1'b1; in_valid = 1'b1;
    a0 = sample_t'($urandom); a1 = sample_t'($urandom); a2 = sample_t'($urandom);
    zero_held();
    repeat (2) @(posedge clk);
    #1 check_outs(1'b0);
    rst = 1'b0;
    beat(1'b0, sample_t'($urandom), sample_t'($urandom), sample_t'($urandom));
    beat(1'b0, 8'h00, 8'h00, 8'h00);

    // Walking one on a1 between fixed 1 and 128: median is a1.
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 8'd1, sample_t'(1 << i), 8'd128);
      chk("walk", {24'd0, out_u}, 32'(1 << i));
    end

    // Ties.
    beat(1'b1, 8'd0, 8'd0, 8'd0);
    chk("tie0", {24'd0, out_u}, 32'd0);
    beat(1'b1, 8'd128, 8'd128, 8'd128);
    chk("tie128", {24'd0, out_u}, 32'd128);
    beat(1'b1, 8'd1, 8'd1, 8'd128);
    chk("tie1", {24'd0, out_u}, 32'd1);

    // All permutations back-to-back.
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, p[i][0], p[i][1], p[i][2]);
      chk("perm", {24'd0, out_u}, 32'd77);
    end

    // Signed vs unsigned ordering of 0x80.
    beat(1'b1, 8'h80, 8'h01, 8'h7F);
    chk("sgn_s", {24'd0, out_s}, 32'h01);
    chk("sgn_u", {24'd0, out_u}, 32'h7F);

    // Idle with X operands: outputs hold.
    beat(1'b0, 8'hxx, 8'hxx, 8'hxx);
    beat(1'b0, 8'hxx, 8'hxx, 8'hxx);

    beat(1'b1, 8'd9, 8'd2, 8'd5);
    chk("mm_med", {24'd0, out_u}, 32'd5);
    beat(1'b1, 8'd250, 8'd128, 8'd5);

    // Async reset between edges clears registered outputs immediately.
    #2 rst = 1'b1;
    #1 zero_held(); sbq.delete();
    check_outs(1'b0);
    // Beat launched while reset held is discarded.
    in_valid = 1'b1; a0 = 8'd40; a1 = 8'd50; a2 = 8'd60;
    @(posedge clk); #1;
    check_outs(1'b0);
    rst = 1'b0;
    beat(1'b0, 8'd1, 8'd2, 8'd3);
    beat(1'b1, 8'd60, 8'd40, 8'd50);
    beat(1'b1, 8'hFF, 8'h00, 8'h81);
    beat(1'b0, 8'h00, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
